// File: rtl/time_stamp_counter.sv
`default_nettype none
// ============================================================================
// Module   : time_stamp_counter
// Purpose  : Free-running time-stamp counter with a 1 PPS / 1 PPMS / 1 PPUS time
//            base. Also contains a GPS 1PPS phase/frequency detector that drives
//            the software PLL, and can re-align the sub-second phase to GPS PPS.
// Revision : 1.0  initial release
// ============================================================================
module time_stamp_counter #(
  parameter int CLK_FREQ = 100_000_000,
  parameter int MS_DIV   = 100_000,
  parameter int US_DIV   = 100
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        gps_1pps,
  input  logic        gps_3dfix_d,
  input  logic        tsc_read,
  input  logic        tsc_sync,
  input  logic        pfd_resync,
  output logic        gps_1pps_d,
  output logic        tsc_1pps_d,
  output logic        pll_trig,
  output logic        pfd_status,
  output logic [31:0] pdiff_1pps,
  output logic [31:0] fdiff_1pps,
  output logic [63:0] tsc_cnt,
  output logic [63:0] tsc_cnt1,
  output logic        tsc_1pps,
  output logic        tsc_1ppms,
  output logic        tsc_1ppus
);

  localparam int c_sub_w = $clog2(CLK_FREQ);
  localparam int c_ms_w  = $clog2(MS_DIV);
  localparam int c_us_w  = $clog2(US_DIV);

  localparam logic [c_sub_w-1:0] c_sub_last = c_sub_w'(CLK_FREQ - 1);
  localparam logic [c_ms_w-1:0]  c_ms_last  = c_ms_w'(MS_DIV - 1);
  localparam logic [c_us_w-1:0]  c_us_last  = c_us_w'(US_DIV - 1);
  // Captures below this value map to a positive phase error after the +2 offset
  localparam logic [31:0]        c_pos_lim  = 32'(CLK_FREQ / 2 - 2);
  localparam logic [31:0]        c_period   = 32'(CLK_FREQ);

  logic [63:0]        r_tsc_cnt;
  logic [63:0]        r_tsc_cnt1;
  logic [c_sub_w-1:0] r_sub_cnt;
  logic [c_ms_w-1:0]  r_ms_cnt;
  logic [c_us_w-1:0]  r_us_cnt;
  logic               r_tsc_1pps;
  logic               r_tsc_1ppms;
  logic               r_tsc_1ppus;
  logic               r_tsc_1pps_d;
  logic               r_gps_s1;
  logic               r_gps_s2;
  logic               r_gps_s3;
  logic               r_gps_1pps_d;
  logic               r_arm;
  logic [c_sub_w-1:0] r_cap;
  logic               r_cap_vld;
  logic               r_cap_sync;
  logic               r_pll_trig;
  logic [31:0]        r_pdiff;
  logic [31:0]        r_fdiff;
  logic [31:0]        r_prev_pdiff;
  logic [1:0]         r_vld_cnt;

  logic               w_arm_now;
  logic               w_resync;
  logic [31:0]        w_cap32;
  logic [31:0]        w_pdiff;
  logic [31:0]        w_fdiff;
  logic               w_first;

  // A sync request arriving on the same edge as a GPS event takes effect immediately
  assign w_arm_now = r_arm | tsc_sync;
  assign w_resync  = r_gps_1pps_d & w_arm_now;

  // Free-running count and software snapshot of it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tsc_cnt  <= '0;
      r_tsc_cnt1 <= '0;
    end else begin
      r_tsc_cnt <= r_tsc_cnt + 64'd1;
      if (tsc_read) r_tsc_cnt1 <= r_tsc_cnt;
    end
  end

  // Sub-second / ms / us dividers; a resync loads them all to their last count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sub_cnt    <= '0;
      r_ms_cnt     <= '0;
      r_us_cnt     <= '0;
      r_tsc_1pps   <= 1'b0;
      r_tsc_1ppms  <= 1'b0;
      r_tsc_1ppus  <= 1'b0;
      r_tsc_1pps_d <= 1'b0;
    end else begin
      r_tsc_1pps   <= (r_sub_cnt == c_sub_last);
      r_tsc_1ppms  <= (r_ms_cnt == c_ms_last);
      r_tsc_1ppus  <= (r_us_cnt == c_us_last);
      r_tsc_1pps_d <= r_tsc_1pps;
      if (w_resync) begin
        r_sub_cnt <= c_sub_last;
        r_ms_cnt  <= c_ms_last;
        r_us_cnt  <= c_us_last;
      end else begin
        r_sub_cnt <= (r_sub_cnt == c_sub_last) ? '0 : r_sub_cnt + 1'b1;
        r_ms_cnt  <= (r_ms_cnt == c_ms_last)   ? '0 : r_ms_cnt + 1'b1;
        r_us_cnt  <= (r_us_cnt == c_us_last)   ? '0 : r_us_cnt + 1'b1;
      end
    end
  end

  // GPS PPS synchronizer, rising-edge detect and resync arm flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_gps_s1     <= 1'b0;
      r_gps_s2     <= 1'b0;
      r_gps_s3     <= 1'b0;
      r_gps_1pps_d <= 1'b0;
      r_arm        <= 1'b0;
    end else begin
      r_gps_s1     <= gps_1pps;
      r_gps_s2     <= r_gps_s1;
      r_gps_s3     <= r_gps_s2;
      r_gps_1pps_d <= r_gps_s2 & ~r_gps_s3;
      r_arm        <= w_arm_now & ~w_resync;
    end
  end

  // Capture stage: sub-second phase at the GPS edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cap      <= '0;
      r_cap_vld  <= 1'b0;
      r_cap_sync <= 1'b0;
    end else begin
      r_cap_vld  <= r_gps_1pps_d;
      r_cap_sync <= w_resync;
      if (r_gps_1pps_d) r_cap <= r_sub_cnt;
    end
  end

  // Phase error is the capture offset by 2 clks, folded into a symmetric range
  always_comb begin
    w_cap32 = 32'(r_cap);
    w_pdiff = '0;
    w_first = pfd_resync | r_cap_sync | (r_vld_cnt == 2'd0);
    if (!r_cap_sync) begin
      if (w_cap32 < c_pos_lim) w_pdiff = w_cap32 + 32'd2;
      else                     w_pdiff = w_cap32 + 32'd2 - c_period;
    end
    w_fdiff = w_first ? 32'd0 : (w_pdiff - r_prev_pdiff);
  end

  // PFD output registers and capture history
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pll_trig   <= 1'b0;
      r_pdiff      <= '0;
      r_fdiff      <= '0;
      r_prev_pdiff <= '0;
      r_vld_cnt    <= '0;
    end else begin
      r_pll_trig <= r_cap_vld;
      if (r_cap_vld) begin
        r_pdiff      <= w_pdiff;
        r_fdiff      <= w_fdiff;
        r_prev_pdiff <= w_pdiff;
        if (w_first)                 r_vld_cnt <= 2'd1;
        else if (r_vld_cnt != 2'd2)  r_vld_cnt <= r_vld_cnt + 2'd1;
      end else if (pfd_resync) begin
        r_prev_pdiff <= '0;
        r_vld_cnt    <= '0;
      end
    end
  end

  assign gps_1pps_d = r_gps_1pps_d;
  assign tsc_1pps_d = r_tsc_1pps_d;
  assign pll_trig   = r_pll_trig;
  assign pfd_status = r_vld_cnt[1] & gps_3dfix_d;
  assign pdiff_1pps = r_pdiff;
  assign fdiff_1pps = r_fdiff;
  assign tsc_cnt    = r_tsc_cnt;
  assign tsc_cnt1   = r_tsc_cnt1;
  assign tsc_1pps   = r_tsc_1pps;
  assign tsc_1ppms  = r_tsc_1ppms;
  assign tsc_1ppus  = r_tsc_1ppus;

endmodule
`default_nettype wire

// File: tb/tb_time_stamp_counter.sv
`default_nettype none
// ============================================================================
// Module   : tb_time_stamp_counter
// Purpose  : Directed self-checking bench for time_stamp_counter, using a
//            reduced time base (4000 clks/s, 400 clks/ms, 40 clks/us).
// Revision : 1.0  initial release
// ============================================================================
module tb_time_stamp_counter;

  logic        clk;
  logic        rst_n;
  logic        gps_1pps;
  logic        gps_3dfix_d;
  logic        tsc_read;
  logic        tsc_sync;
  logic        pfd_resync;
  logic        gps_1pps_d;
  logic        tsc_1pps_d;
  logic        pll_trig;
  logic        pfd_status;
  logic [31:0] pdiff_1pps;
  logic [31:0] fdiff_1pps;
  logic [63:0] tsc_cnt;
  logic [63:0] tsc_cnt1;
  logic        tsc_1pps;
  logic        tsc_1ppms;
  logic        tsc_1ppus;

  int n_checks = 0;
  int n_fails  = 0;
  int e        = 0;
  int pll_cnt  = 0;

  time_stamp_counter #(
    .CLK_FREQ (4000),
    .MS_DIV   (400),
    .US_DIV   (40)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .gps_1pps    (gps_1pps),
    .gps_3dfix_d (gps_3dfix_d),
    .tsc_read    (tsc_read),
    .tsc_sync    (tsc_sync),
    .pfd_resync  (pfd_resync),
    .gps_1pps_d  (gps_1pps_d),
    .tsc_1pps_d  (tsc_1pps_d),
    .pll_trig    (pll_trig),
    .pfd_status  (pfd_status),
    .pdiff_1pps  (pdiff_1pps),
    .fdiff_1pps  (fdiff_1pps),
    .tsc_cnt     (tsc_cnt),
    .tsc_cnt1    (tsc_cnt1),
    .tsc_1pps    (tsc_1pps),
    .tsc_1ppms   (tsc_1ppms),
    .tsc_1ppus   (tsc_1ppus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count pll_trig pulses seen on rising edges
  always @(posedge clk) if (pll_trig) pll_cnt <= pll_cnt + 1;

  task automatic step_to(input int target);
    while (e < target) begin
      @(posedge clk);
      e = e + 1;
    end
    #1;
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s at edge %0d: observed=%0b expected=%0b", tag, e, obs, exp);
    end
  endtask

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s at edge %0d: observed=%0d expected=%0d", tag, e, $signed(obs), $signed(exp));
    end
  endtask

  task automatic check64(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s at edge %0d: observed=%0d expected=%0d", tag, e, obs, exp);
    end
  endtask

  initial begin
    rst_n       = 1'b0;
    gps_1pps    = 1'b0;
    gps_3dfix_d = 1'b1;
    tsc_read    = 1'b0;
    tsc_sync    = 1'b0;
    pfd_resync  = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check64("rst_tsc_cnt", tsc_cnt, 64'd0);
    check64("rst_tsc_cnt1", tsc_cnt1, 64'd0);
    check1("rst_tsc_1pps", tsc_1pps, 1'b0);
    check32("rst_pdiff", pdiff_1pps, 32'd0);
    check1("rst_pfd_status", pfd_status, 1'b0);
    rst_n = 1'b1;
    e = 0;

    // Time base after reset release
    step_to(1);    check64("tsc_cnt_e1", tsc_cnt, 64'd1);
    step_to(39);   check1("ppus_e39", tsc_1ppus, 1'b0);
    step_to(40);   check1("ppus_e40", tsc_1ppus, 1'b1);
                   check1("ppms_e40", tsc_1ppms, 1'b0);
    step_to(400);  check1("ppms_e400", tsc_1ppms, 1'b1);
    step_to(3999); check1("pps_e3999", tsc_1pps, 1'b0);
    step_to(4000); check1("pps_e4000", tsc_1pps, 1'b1);
                   check1("ppms_e4000", tsc_1ppms, 1'b1);
                   check1("ppus_e4000", tsc_1ppus, 1'b1);
    step_to(4001); check1("pps_e4001", tsc_1pps, 1'b0);
                   check1("pps_d_e4001", tsc_1pps_d, 1'b1);
    tsc_read = 1'b1;
    step_to(4002); tsc_read = 1'b0;
                   check64("tsc_cnt1_snap", tsc_cnt1, 64'd4001);
                   check64("tsc_cnt_e4002", tsc_cnt, 64'd4002);

    // GPS 1000 clks late relative to the TSC second
    step_to(4995); gps_1pps = 1'b1;
    step_to(4997); check1("gps_d_e4997", gps_1pps_d, 1'b0);
    step_to(4998); check1("gps_d_e4998", gps_1pps_d, 1'b1);
    step_to(4999); check1("gps_d_e4999", gps_1pps_d, 1'b0);
                   check1("trig_e4999", pll_trig, 1'b0);
    step_to(5000); gps_1pps = 1'b0;
                   check1("trig_e5000", pll_trig, 1'b1);
                   check32("pdiff_late", pdiff_1pps, 32'd1000);
                   check32("fdiff_first", fdiff_1pps, 32'd0);
                   check1("status_one_cap", pfd_status, 1'b0);
    step_to(5001); check1("trig_e5001", pll_trig, 1'b0);

    // GPS 1000 clks early
    step_to(6995); gps_1pps = 1'b1;
    step_to(7000); gps_1pps = 1'b0;
                   check1("trig_e7000", pll_trig, 1'b1);
                   check32("pdiff_early", pdiff_1pps, -32'sd1000);
                   check32("fdiff_early", fdiff_1pps, -32'sd2000);
                   check1("status_two_caps", pfd_status, 1'b1);
    step_to(7001); gps_3dfix_d = 1'b0; #1;
                   check1("status_no_fix", pfd_status, 1'b0);
                   gps_3dfix_d = 1'b1;

    // Second at ~11000 skipped; next capture compares against held pdiff
    step_to(14989); gps_1pps = 1'b1;
    step_to(14993); check32("pll_cnt_skip", pll_cnt, 32'd2);
                    check32("pdiff_hold", pdiff_1pps, -32'sd1000);
    step_to(14994); gps_1pps = 1'b0;
                    check1("trig_e14994", pll_trig, 1'b1);
                    check32("pdiff_after_skip", pdiff_1pps, -32'sd1006);
                    check32("fdiff_after_skip", fdiff_1pps, -32'sd6);

    // PFD history clear
    step_to(15000); pfd_resync = 1'b1;
    step_to(15001); pfd_resync = 1'b0;
                    check1("status_after_clr", pfd_status, 1'b0);
                    check32("pdiff_hold_clr", pdiff_1pps, -32'sd1006);
    step_to(17499); gps_1pps = 1'b1;
    step_to(17504); gps_1pps = 1'b0;
                    check32("pdiff_post_clr", pdiff_1pps, 32'd1504);
                    check32("fdiff_post_clr", fdiff_1pps, 32'd0);
                    check1("status_post_clr", pfd_status, 1'b0);

    // Re-align sub-second phase to GPS
    step_to(18000); tsc_sync = 1'b1;
    step_to(18001); tsc_sync = 1'b0;
    step_to(19299); gps_1pps = 1'b1;
    step_to(19303); check1("pps_resync_e19303", tsc_1pps, 1'b0);
    step_to(19304); gps_1pps = 1'b0;
                    check1("pps_resync_e19304", tsc_1pps, 1'b1);
                    check1("trig_resync", pll_trig, 1'b1);
                    check32("pdiff_resync", pdiff_1pps, 32'd0);
                    check32("fdiff_resync", fdiff_1pps, 32'd0);
    step_to(20000); check1("pps_old_phase", tsc_1pps, 1'b0);
    step_to(23304); check1("pps_new_phase", tsc_1pps, 1'b1);
                    check1("ppms_new_phase", tsc_1ppms, 1'b1);
                    check1("ppus_new_phase", tsc_1ppus, 1'b1);
                    gps_1pps = 1'b1;
    step_to(23309); gps_1pps = 1'b0;
                    check32("pdiff_after_sync", pdiff_1pps, 32'd5);
                    check32("fdiff_after_sync", fdiff_1pps, 32'd5);
                    check1("status_after_sync", pfd_status, 1'b1);

    // Reset mid-second with resync armed
    step_to(24000); tsc_sync = 1'b1;
    step_to(24001); tsc_sync = 1'b0;
    step_to(25000); rst_n = 1'b0; #1;
                    check64("mid_rst_tsc_cnt", tsc_cnt, 64'd0);
                    check64("mid_rst_tsc_cnt1", tsc_cnt1, 64'd0);
                    check32("mid_rst_pdiff", pdiff_1pps, 32'd0);
                    check32("mid_rst_fdiff", fdiff_1pps, 32'd0);
                    check1("mid_rst_status", pfd_status, 1'b0);
                    check1("mid_rst_pps_d", tsc_1pps_d, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    e = 0;
    step_to(999);  gps_1pps = 1'b1;
    step_to(1004); gps_1pps = 1'b0;
                   check1("no_arm_pps", tsc_1pps, 1'b0);
                   check1("no_arm_trig", pll_trig, 1'b1);
                   check32("no_arm_pdiff", pdiff_1pps, 32'd1004);
                   check32("no_arm_fdiff", fdiff_1pps, 32'd0);
                   check64("no_arm_tsc_cnt", tsc_cnt, 64'd1004);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
`default_nettype wire
